// File: rtl/dmem_bus_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dmem_bus_pkg : FSM state type and byte-enable constants for dmem_bus_bridge
// rev 1.0
// -----------------------------------------------------------------------------
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_RDATA = 2'd2,
    S_DONE  = 2'd3
  } dmem_state_t;

  localparam int DMEM_BE_W = 32 / 8;

  // All-zero enables mark a read; resized by users whose DATA_W differs.
  localparam logic [DMEM_BE_W-1:0] BE_NONE = '0;

endpackage : dmem_bus_pkg
`default_nettype wire

// File: rtl/dmem_bus_bridge_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dmem_bus_bridge_if : bus between dmem_bus_bridge (master) and data memory
// rev 1.0
// -----------------------------------------------------------------------------
interface dmem_bus_bridge_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic                  bus_req;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_be;
  logic                  bus_we;
  logic                  bus_gnt;
  logic                  bus_rvalid;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_wdata, bus_be, bus_we,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_wdata, bus_be, bus_we,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface : dmem_bus_bridge_if
`default_nettype wire

// File: rtl/dmem_bus_bridge.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dmem_bus_bridge : MEM-stage load/store to single-outstanding data-memory bus
// Optional: DMEM_POSTED_WRITE_EN (writes retire without stalling)  rev 1.0
// -----------------------------------------------------------------------------
module dmem_bus_bridge
  import dmem_bus_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                stall,
  dmem_bus_bridge_if.master   bus
);

  localparam int BE_W = DATA_W / 8;

`ifdef DMEM_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;

  logic is_write_q;
  logic req_is_write;
  logic load;
  logic capture;
  logic bus_req_w;

  assign is_write_q   = (be_q != BE_W'(BE_NONE));
  assign req_is_write = (req_be != BE_W'(BE_NONE));
  assign load         = (state_q == S_IDLE) && req_valid;
  assign capture      = (state_q == S_RDATA) && bus.bus_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.bus_gnt) begin
          if (!is_write_q) begin
            state_d = S_RDATA;
          end else if (POSTED) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RDATA: begin
        if (bus.bus_rvalid) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A posted write has already retired, so only a newer request stalls behind it.
  always_comb begin
    stall     = 1'b0;
    bus_req_w = 1'b0;
    case (state_q)
      S_IDLE:  stall = req_valid && !(POSTED && req_is_write);
      S_ADDR: begin
        bus_req_w = 1'b1;
        stall     = (POSTED && is_write_q) ? req_valid : 1'b1;
      end
      S_RDATA: stall = 1'b1;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
    if (!rst_n) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= BE_W'(BE_NONE);
      rdata_q <= '0;
    end else begin
      if (load) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (capture) begin
        rdata_q <= bus.bus_rdata;
      end
    end
  end

  assign bus.bus_req   = bus_req_w;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_we    = is_write_q;
  assign rsp_rdata     = rdata_q;

endmodule : dmem_bus_bridge
`default_nettype wire
